// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin bus grant arbiter.
package arb_pkg;
   localparam int NUM_REQ = 8;
   localparam int SEL_W   = 3;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_TURN
   } arb_state_t;
endpackage

// File: rtl/decoder_3_to_8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module Decoder_3_to_8 (
   input  logic       enable_bit,
   input  logic [2:0] select_bits,
   output logic [7:0] decoded_bits
);
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_dec
         assign decoded_bits[gi] = enable_bit && (select_bits == 3'(gi));
      end
   endgenerate
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after last_owner, wrapping 7->0.
module rr_pick
   import arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_bits,
   input  logic [SEL_W-1:0]   last_owner,
   output logic [SEL_W-1:0]   pick_idx,
   output logic               pick_valid
);
   // rot_bits[k] is the request of requester last_owner+1+k, so bit 0 has top priority
   logic [NUM_REQ-1:0] rot_bits;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
         logic [SEL_W-1:0] src_idx;
         assign src_idx      = last_owner + SEL_W'(gi + 1);
         assign rot_bits[gi] = req_bits[src_idx];
      end
   endgenerate

   always_comb begin
      pick_idx   = '0;
      pick_valid = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot_bits[i]) begin
            pick_valid = 1'b1;
            pick_idx   = last_owner + SEL_W'(i + 1);
         end
      end
   end
endmodule

// File: rtl/bus_grant_arbiter.sv
// Round-robin arbiter granting one shared resource to 8 requesters.
// Optional grant timeout enabled by defining ARB_TIMEOUT_EN.
module bus_grant_arbiter
   import arb_pkg::*;
#(
   parameter int TURN_CYCLES    = 1,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_bits,
   input  logic [NUM_REQ-1:0] done_bits,
   output logic [SEL_W-1:0]   grant_select_bits,
   output logic               grant_enable_bit,
   output logic [NUM_REQ-1:0] grant_bits,
   output logic               busy_bit,
   output logic               timeout_bit
);
   arb_state_t       state_reg, state_next;
   logic [SEL_W-1:0] owner_reg, owner_next;
   logic             enable_reg, enable_next;
   logic [SEL_W-1:0] last_owner_reg, last_owner_next;
   logic [3:0]       turn_cnt_reg, turn_cnt_next;
   logic [SEL_W-1:0] pick_idx;
   logic             pick_valid;
   logic             release_now;
   logic             expire_now;

   rr_pick u_pick (
      .req_bits   (req_bits),
      .last_owner (last_owner_reg),
      .pick_idx   (pick_idx),
      .pick_valid (pick_valid)
   );

   assign release_now = done_bits[owner_reg] | ~req_bits[owner_reg];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] hold_cnt_reg, hold_cnt_next;
   logic       timeout_reg, timeout_next;

   // Expiring at TIMEOUT_CYCLES-1 leaves the grant visible for exactly TIMEOUT_CYCLES cycles
   assign expire_now  = (hold_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
   assign timeout_bit = timeout_reg;
`else
   assign expire_now  = 1'b0;
   assign timeout_bit = 1'b0;
`endif

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      enable_next     = enable_reg;
      last_owner_next = last_owner_reg;
      turn_cnt_next   = turn_cnt_reg;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_next   = hold_cnt_reg;
      timeout_next    = 1'b0;
`endif
      case (state_reg)
         ARB_IDLE: begin
            if (pick_valid) begin
               owner_next      = pick_idx;
               enable_next     = 1'b1;
               last_owner_next = pick_idx;
               state_next      = ARB_GRANT;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_next   = '0;
`endif
            end
         end
         ARB_GRANT: begin
            if (release_now || expire_now) begin
               enable_next   = 1'b0;
               turn_cnt_next = '0;
               state_next    = (TURN_CYCLES == 0) ? ARB_IDLE : ARB_TURN;
`ifdef ARB_TIMEOUT_EN
               // A genuine release wins over a coincident expiry
               timeout_next  = expire_now & ~release_now;
`endif
            end else begin
`ifdef ARB_TIMEOUT_EN
               hold_cnt_next = hold_cnt_reg + 8'd1;
`endif
            end
         end
         ARB_TURN: begin
            if (turn_cnt_reg == 4'(TURN_CYCLES - 1)) begin
               state_next = ARB_IDLE;
            end else begin
               turn_cnt_next = turn_cnt_reg + 4'd1;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ARB_IDLE;
         owner_reg      <= '0;
         enable_reg     <= 1'b0;
         last_owner_reg <= 3'd7;
         turn_cnt_reg   <= '0;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_reg   <= '0;
         timeout_reg    <= 1'b0;
`endif
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         enable_reg     <= enable_next;
         last_owner_reg <= last_owner_next;
         turn_cnt_reg   <= turn_cnt_next;
`ifdef ARB_TIMEOUT_EN
         hold_cnt_reg   <= hold_cnt_next;
         timeout_reg    <= timeout_next;
`endif
      end
   end

   assign grant_select_bits = owner_reg;
   assign grant_enable_bit  = enable_reg;
   assign busy_bit          = (state_reg != ARB_IDLE);

   Decoder_3_to_8 u_dec (
      .enable_bit   (enable_reg),
      .select_bits  (owner_reg),
      .decoded_bits (grant_bits)
   );
endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Self-checking bench for bus_grant_arbiter: expected grant order is queued and checked on each new grant.
module tb_bus_grant_arbiter;
   localparam int TURN_CYCLES    = 1;
   localparam int TIMEOUT_CYCLES = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req_bits;
   logic [7:0] done_bits;
   logic [2:0] grant_select_bits;
   logic       grant_enable_bit;
   logic [7:0] grant_bits;
   logic       busy_bit;
   logic       timeout_bit;

   int         checks      = 0;
   int         failures    = 0;
   int         grant_count = 0;
   int         exp_grants  = 0;
   logic [2:0] exp_q[$];
   logic       prev_en     = 1'b0;

   always #5 clk = ~clk;

   bus_grant_arbiter #(
      .TURN_CYCLES    (TURN_CYCLES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .req_bits          (req_bits),
      .done_bits         (done_bits),
      .grant_select_bits (grant_select_bits),
      .grant_enable_bit  (grant_enable_bit),
      .grant_bits        (grant_bits),
      .busy_bit          (busy_bit),
      .timeout_bit       (timeout_bit)
   );

   // Scoreboard: every rising grant_enable_bit pops one expected owner
   always @(negedge clk) begin
      logic [2:0] exp_sel;
      logic [7:0] exp_bits;
      if (!rst_n) begin
         prev_en = 1'b0;
      end else begin
         if (grant_enable_bit && !prev_en) begin
            grant_count++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL unexpected_grant: select=%0d, no grant expected", grant_select_bits);
            end else begin
               exp_sel  = exp_q.pop_front();
               exp_bits = 8'h01 << exp_sel;
               if (grant_select_bits !== exp_sel) begin
                  failures++;
                  $display("FAIL grant_order: got %0d expected %0d", grant_select_bits, exp_sel);
               end
               checks++;
               if (grant_bits !== exp_bits) begin
                  failures++;
                  $display("FAIL grant_onehot: got %h expected %h", grant_bits, exp_bits);
               end
               $display("grant #%0d owner=%0d grant_bits=%h", grant_count, grant_select_bits, grant_bits);
            end
         end
         prev_en = grant_enable_bit;
      end
   end

   task automatic expect_grant(input logic [2:0] idx);
      exp_q.push_back(idx);
      exp_grants++;
   endtask

   task automatic wait_grant();
      for (int c = 0; c < 40 && grant_count < exp_grants; c++) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (grant_count != exp_grants) begin
         failures++;
         $display("FAIL grant_wait: grants=%0d expected %0d", grant_count, exp_grants);
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_bits  = 8'hFF;
      done_bits = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({grant_enable_bit, grant_select_bits, grant_bits, busy_bit, timeout_bit} !== 14'd0) begin
         failures++;
         $display("FAIL reset_outputs: en=%b sel=%0d bits=%h busy=%b to=%b expected all 0",
                  grant_enable_bit, grant_select_bits, grant_bits, busy_bit, timeout_bit);
      end
      expect_grant(3'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      wait_grant();
      checks++;
      if (busy_bit !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_busy: got %b expected 1", busy_bit);
      end
   endtask

   task automatic test_round_robin();
      int gap;
      for (int i = 0; i < 8; i++) begin
         repeat (2) @(posedge clk);
         #1 done_bits = 8'h01 << i;
         expect_grant(3'(i + 1));
         @(posedge clk);
         #1 done_bits = 8'h00;
         gap = 0;
         for (int c = 0; c < 20 && grant_count < exp_grants; c++) begin
            @(negedge clk);
            #1;
            if (grant_count < exp_grants && !grant_enable_bit) gap++;
         end
         checks++;
         if (gap != TURN_CYCLES + 1) begin
            failures++;
            $display("FAIL turn_gap: got %0d low cycles expected %0d", gap, TURN_CYCLES + 1);
         end
      end
   endtask

   task automatic test_wrap();
      @(posedge clk);
      #1 req_bits = 8'h04;
      expect_grant(3'd2);
      wait_grant();
      expect_grant(3'd7);
      @(posedge clk);
      #1 req_bits = 8'h84;
      done_bits = 8'h04;
      @(posedge clk);
      #1 done_bits = 8'h00;
      wait_grant();
      expect_grant(3'd2);
      @(posedge clk);
      #1 done_bits = 8'h80;
      @(posedge clk);
      #1 done_bits = 8'h00;
      wait_grant();
   endtask

   task automatic test_release_rules();
      @(posedge clk);
      #1 req_bits = 8'h20;
      expect_grant(3'd5);
      wait_grant();
      @(posedge clk);
      #1 req_bits = 8'h22;
      done_bits = 8'h02;
      @(posedge clk);
      #1 done_bits = 8'h00;
      repeat (2) begin
         @(negedge clk);
         #1;
         checks++;
         if (grant_enable_bit !== 1'b1 || grant_select_bits !== 3'd5) begin
            failures++;
            $display("FAIL nonowner_done: en=%b sel=%0d expected en=1 sel=5",
                     grant_enable_bit, grant_select_bits);
         end
      end
      expect_grant(3'd1);
      req_bits = 8'h02;
      repeat (2) begin
         @(negedge clk);
         #1;
         checks++;
         if (timeout_bit !== 1'b0) begin
            failures++;
            $display("FAIL release_no_timeout: got %b expected 0", timeout_bit);
         end
      end
      wait_grant();
   endtask

   task automatic test_timeout();
      int hold;
      @(posedge clk);
      #1 req_bits = 8'h08;
      expect_grant(3'd3);
      wait_grant();
      @(posedge clk);
      #1 req_bits = 8'h18;
      expect_grant(3'd4);
`ifdef ARB_TIMEOUT_EN
      hold = 1;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         #1;
         if (!grant_enable_bit) break;
         hold++;
      end
      checks++;
      if (hold != TIMEOUT_CYCLES) begin
         failures++;
         $display("FAIL timeout_hold: got %0d cycles expected %0d", hold, TIMEOUT_CYCLES);
      end
      checks++;
      if (timeout_bit !== 1'b1) begin
         failures++;
         $display("FAIL timeout_pulse: got %b expected 1", timeout_bit);
      end
      @(negedge clk);
      #1;
      checks++;
      if (timeout_bit !== 1'b0) begin
         failures++;
         $display("FAIL timeout_pulse_width: got %b expected 0", timeout_bit);
      end
`else
      hold = 1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         #1;
         if (grant_enable_bit && grant_select_bits == 3'd3 && !timeout_bit) hold++;
      end
      checks++;
      if (hold != 21) begin
         failures++;
         $display("FAIL hold_forever: got %0d held cycles expected 21", hold);
      end
      @(posedge clk);
      #1 done_bits = 8'h08;
      @(posedge clk);
      #1 done_bits = 8'h00;
`endif
      wait_grant();
      @(posedge clk);
      #1 req_bits = 8'h40;
      expect_grant(3'd6);
      wait_grant();
   endtask

   task automatic test_async_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({grant_enable_bit, grant_select_bits, grant_bits, busy_bit, timeout_bit} !== 14'd0) begin
         failures++;
         $display("FAIL async_reset: en=%b sel=%0d bits=%h busy=%b to=%b expected all 0",
                  grant_enable_bit, grant_select_bits, grant_bits, busy_bit, timeout_bit);
      end
      req_bits = 8'h41;
      repeat (2) @(posedge clk);
      expect_grant(3'd0);
      #1 rst_n = 1'b1;
      wait_grant();
      @(posedge clk);
      #1 req_bits = 8'h00;
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (busy_bit !== 1'b0 || grant_bits !== 8'h00) begin
         failures++;
         $display("FAIL idle_after_release: busy=%b bits=%h expected 0/00", busy_bit, grant_bits);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_wrap();
      test_release_rules();
      test_timeout();
      test_async_reset();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_grants: got %0d outstanding expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end
endmodule
